// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, instruction field
// positions, the NOP word, and the beq offset helper.
package mips_pkg;
   localparam logic [5:0]  OP_RTYPE = 6'b000000;
   localparam logic [5:0]  OP_LW    = 6'b100011;
   localparam logic [5:0]  OP_SW    = 6'b101011;
   localparam logic [5:0]  OP_BEQ   = 6'b000100;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;

   // Sign-extended word offset of a beq immediate, as a byte offset.
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x 32, one synchronous write port and one
// registered read port with read enable.
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read port; o_rdata updates only when i_re is high
//   o_rdata          registered read data (old data on same-cycle write)
module instr_mem
   import mips_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, instruction memory, and the IR
// presented to the decoder. Redirects on a taken beq with one bubble.
//   i_clk, i_reset (sync, active high)
//   i_stall           hold PC/IR this cycle
//   i_branch, i_zero  beq decode and ALU Zero for the instruction in IR
//   i_imem_*          instruction memory load port
//   o_instr + fields  registered instruction word and its slices
//   o_pc, o_pc_plus4  fetch PC, and PC+4 of the instruction in IR
//   o_valid           IR holds a real instruction
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0,
   localparam int         AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_stall,
   input  logic          i_branch,
   input  logic          i_zero,
   input  logic          i_imem_we,
   input  logic [AW-1:0] i_imem_waddr,
   input  logic [31:0]   i_imem_wdata,
   output logic [31:0]   o_instr,
   output logic [5:0]    o_op,
   output logic [4:0]    o_rs,
   output logic [4:0]    o_rt,
   output logic [4:0]    o_rd,
   output logic [5:0]    o_funct,
   output logic [15:0]   o_imm,
   output logic [31:0]   o_pc,
   output logic [31:0]   o_pc_plus4,
   output logic          o_valid
);
   logic [31:0] r_pc, r_pc4;
   logic        r_valid;
   logic [31:0] w_rdata, w_instr, w_pc_inc, w_target;
   logic        w_taken, w_fetch;

   assign w_taken  = i_branch & i_zero & r_valid;
   assign w_fetch  = ~i_reset & ~w_taken & ~i_stall;
   assign w_pc_inc = r_pc + 32'd4;

   // The memory read register is the IR; bubbles and reset are expressed
   // by masking it with valid rather than clearing the RAM output.
   assign w_instr  = r_valid ? w_rdata : NOP_WORD;
   assign w_target = r_pc4 + br_offset(w_instr[IMM_MSB:IMM_LSB]);

   instr_mem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
      .i_clk   (i_clk),
      .i_we    (i_imem_we),
      .i_waddr (i_imem_waddr),
      .i_wdata (i_imem_wdata),
      .i_re    (w_fetch),
      .i_raddr (r_pc[AW+1:2]),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc    <= RESET_PC;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
      end else if (w_taken) begin
         // Wrong-path word already fetched is squashed; target fetched next.
         r_pc    <= w_target;
         r_valid <= 1'b0;
      end else if (!i_stall) begin
         r_pc    <= w_pc_inc;
         r_pc4   <= w_pc_inc;
         r_valid <= 1'b1;
      end
   end

   assign o_instr    = w_instr;
   assign o_op       = w_instr[OP_MSB:OP_LSB];
   assign o_rs       = w_instr[RS_MSB:RS_LSB];
   assign o_rt       = w_instr[RT_MSB:RT_LSB];
   assign o_rd       = w_instr[RD_MSB:RD_LSB];
   assign o_funct    = w_instr[FUNCT_MSB:FUNCT_LSB];
   assign o_imm      = w_instr[IMM_MSB:IMM_LSB];
   assign o_pc       = r_pc;
   assign o_pc_plus4 = r_pc4;
   assign o_valid    = r_valid;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset, stall, branch, zero, we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic [31:0]   instr, pc, pc4;
   logic [5:0]    op, funct;
   logic [4:0]    rs, rt, rd;
   logic [15:0]   imm;
   logic          valid;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_pc4, m_instr;
   logic        m_valid;

   logic [31:0] W [8];

   always #5 clk = ~clk;

   instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_branch(branch),
      .i_zero(zero), .i_imem_we(we), .i_imem_waddr(waddr), .i_imem_wdata(wdata),
      .o_instr(instr), .o_op(op), .o_rs(rs), .o_rt(rt), .o_rd(rd),
      .o_funct(funct), .o_imm(imm), .o_pc(pc), .o_pc_plus4(pc4), .o_valid(valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the fetch unit described directly from its rules.
   task automatic model_edge();
      logic [31:0] offs;
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (branch && zero && m_valid) begin
         offs    = {{16{m_instr[15]}}, m_instr[15:0]} * 4;
         m_pc    = m_pc4 + offs;
         m_instr = 32'h0;
         m_valid = 1'b0;
      end else if (!stall) begin
         m_instr = m_mem[(m_pc / 4) % DEPTH];
         m_pc4   = m_pc + 4;
         m_pc    = m_pc + 4;
         m_valid = 1'b1;
      end
      if (we) m_mem[waddr] = wdata;
   endtask

   task automatic compare();
      chk("instr", instr, m_instr);
      chk("op",    {26'b0, op},    {26'b0, m_instr[31:26]});
      chk("rs",    {27'b0, rs},    {27'b0, m_instr[25:21]});
      chk("rt",    {27'b0, rt},    {27'b0, m_instr[20:16]});
      chk("rd",    {27'b0, rd},    {27'b0, m_instr[15:11]});
      chk("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
      chk("imm",   {16'b0, imm},   {16'b0, m_instr[15:0]});
      chk("pc",    pc,  m_pc);
      chk("pc4",   pc4, m_pc4);
      chk("valid", {31'b0, valid}, {31'b0, m_valid});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1 compare();
   endtask

   task automatic idle();
      stall = 0; branch = 0; zero = 0; we = 0; waddr = '0; wdata = '0;
   endtask

   initial begin
      W[0] = 32'h012A4020; W[1] = 32'h8D280004; W[2] = 32'hAD280008; W[3] = 32'h11090002;
      W[4] = 32'h014B4822; W[5] = 32'h8C010010; W[6] = 32'h00221820; W[7] = 32'hAC030014;
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      idle();
      reset = 1;
      @(negedge clk);
      // fill memory during reset (writes allowed), then the directed program
      for (int i = 0; i < DEPTH; i++) begin
         we = 1; waddr = AW'(i); wdata = $urandom; cyc();
      end
      for (int i = 0; i < 8; i++) begin
         we = 1; waddr = AW'(i); wdata = W[i]; cyc();
      end
      idle();
      // 1 reset
      cyc(); cyc();
      chk("t1_pc", pc, 32'h0); chk("t1_instr", instr, 32'h0); chk("t1_valid", {31'b0, valid}, 32'd0);
      reset = 0;
      cyc();
      chk("t1_valid1", {31'b0, valid}, 32'd1); chk("t1_pc4", pc, 32'h4);
      // 2 sequential
      chk("t2_op0", {26'b0, op}, 32'h00); chk("t2_p0", pc4, 32'd4);
      cyc(); chk("t2_op1", {26'b0, op}, 32'h23); chk("t2_p1", pc4, 32'd8);
      cyc(); chk("t2_op2", {26'b0, op}, 32'h2B); chk("t2_p2", pc4, 32'd12);
      cyc(); chk("t2_op3", {26'b0, op}, 32'h04); chk("t2_p3", pc4, 32'd16);
      // 3 taken beq
      branch = 1; zero = 1; cyc();
      chk("t3_valid", {31'b0, valid}, 32'd0); chk("t3_pc", pc, 32'h18);
      idle(); cyc();
      chk("t3_instr", instr, W[6]); chk("t3_pc4", pc4, 32'h1C);
      // 4 not taken
      reset = 1; cyc(); reset = 0;
      repeat (4) cyc();
      branch = 1; zero = 0; cyc();
      chk("t4_instr", instr, W[4]); chk("t4_valid", {31'b0, valid}, 32'd1);
      idle();
      // 5 stall
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc(); chk("t5_instr", instr, W[4]); chk("t5_pc", pc, 32'h14);
      end
      stall = 0; cyc();
      chk("t5_resume", instr, W[5]); chk("t5_pc2", pc, 32'h18);
      reset = 1; cyc(); reset = 0;
      repeat (4) cyc();
      stall = 1; branch = 1; zero = 1; cyc();
      chk("t5_stbr_pc", pc, 32'h18); chk("t5_stbr_v", {31'b0, valid}, 32'd0);
      idle();
      // 6 backward branch, then reset during a taken branch
      reset = 1; we = 1; waddr = 6'd3; wdata = 32'h1109FFFF; cyc();
      idle(); reset = 0;
      repeat (4) cyc();
      chk("t6_pc4", pc4, 32'h10);
      branch = 1; zero = 1; cyc();
      chk("t6_pc", pc, 32'h0C); chk("t6_valid", {31'b0, valid}, 32'd0);
      idle(); cyc();
      chk("t6_instr", instr, 32'h1109FFFF);
      reset = 1; branch = 1; zero = 1; cyc();
      chk("t6_rst_pc", pc, 32'h0); chk("t6_rst_v", {31'b0, valid}, 32'd0);
      idle(); reset = 0;
      // same-cycle write/read returns old data
      cyc();
      we = 1; waddr = 6'd1; wdata = 32'hDEADBEEF; cyc();
      chk("wr_old", instr, W[1]);
      idle();
      // randomized
      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 59) == 0);
         stall  = ($urandom_range(0, 4) == 0);
         branch = ($urandom_range(0, 3) == 0);
         zero   = $urandom_range(0, 1) == 1;
         we     = ($urandom_range(0, 5) == 0);
         waddr  = AW'($urandom_range(0, DEPTH - 1));
         wdata  = $urandom;
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
